// File: rtl/mem_arbiter.sv
// Shares one RAM port among NREQ cache requesters (even index = icache, odd = dcache).
// One access in flight at a time; the winner's command is latched and held until ram_ready.
module mem_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_PRIO = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_store,
    output logic [NREQ-1:0]      req_wait,
    output logic [31:0]          req_load,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_store,
    input  logic [31:0]          ram_load,
    input  logic                 ram_ready
);

    localparam int IW   = $clog2(NREQ);
    localparam int STEP = (DATA_PRIO != 0) ? 2 : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_idx_q, grant_idx_d;
    logic            ram_ren_q, ram_ren_d;
    logic            ram_wen_q, ram_wen_d;
    logic [31:0]     ram_addr_q, ram_addr_d;
    logic [31:0]     ram_store_q, ram_store_d;
    logic            dropped_q, dropped_d;
    logic [IW-1:0]   ptr_odd_q, ptr_odd_d;
    logic [IW-1:0]   ptr_even_q, ptr_even_d;
    logic [IW-1:0]   ptr_all_q, ptr_all_d;

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] odd_mask;
    logic [31:0]     addr_arr  [NREQ];
    logic [31:0]     store_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign pending[gi]   = req_ren[gi] | req_wen[gi];
        assign odd_mask[gi]  = 1'(gi % 2);
        assign addr_arr[gi]  = req_addr[32*gi +: 32];
        assign store_arr[gi] = req_store[32*gi +: 32];
    end

    // Returns {found, index} of the first set mask bit at or above ptr, wrapping.
    // Scanning downward and overwriting leaves the nearest hit from ptr.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   ptr);
        logic [IW:0]   res;
        logic [IW-1:0] idx_v;
        int            j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j     = (int'(ptr) + k) % NREQ;
            idx_v = IW'(j);
            if (mask[idx_v]) begin
                res = {1'b1, idx_v};
            end
        end
        return res;
    endfunction

    logic [IW:0]   pick_odd, pick_even, pick_all;
    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] ptr_next;

    always_comb begin
        pick_odd  = rr_pick(pending & odd_mask, ptr_odd_q);
        pick_even = rr_pick(pending & ~odd_mask, ptr_even_q);
        pick_all  = rr_pick(pending, ptr_all_q);
        win_valid = 1'b0;
        win_idx   = '0;
        if (DATA_PRIO != 0) begin
            if (pick_odd[IW]) begin
                win_valid = 1'b1;
                win_idx   = pick_odd[IW-1:0];
            end else if (pick_even[IW]) begin
                win_valid = 1'b1;
                win_idx   = pick_even[IW-1:0];
            end
        end else begin
            win_valid = pick_all[IW];
            win_idx   = pick_all[IW-1:0];
        end
        ptr_next = IW'((int'(grant_idx_q) + STEP) % NREQ);
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        dropped_d   = dropped_q;
        ptr_odd_d   = ptr_odd_q;
        ptr_even_d  = ptr_even_q;
        ptr_all_d   = ptr_all_q;
        req_wait    = '1;
        req_load    = '0;

        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d     = S_GRANT;
                    grant_idx_d = win_idx;
                    ram_wen_d   = req_wen[win_idx];
                    ram_ren_d   = ~req_wen[win_idx];
                    ram_addr_d  = addr_arr[win_idx];
                    ram_store_d = store_arr[win_idx];
                    dropped_d   = 1'b0;
                end
            end
            S_GRANT: begin
                // A grantee that lets go at any point forfeits the result, but the
                // RAM access itself is never aborted.
                if (!pending[grant_idx_q]) begin
                    dropped_d = 1'b1;
                end
                if (ram_ready) begin
                    state_d   = S_IDLE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    dropped_d = 1'b0;
                    if (!dropped_q && pending[grant_idx_q] && !RST) begin
                        req_wait[grant_idx_q] = 1'b0;
                        req_load              = ram_load;
                        if (DATA_PRIO != 0) begin
                            if (grant_idx_q[0]) begin
                                ptr_odd_d = ptr_next;
                            end else begin
                                ptr_even_d = ptr_next;
                            end
                        end else begin
                            ptr_all_d = ptr_next;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            dropped_q   <= 1'b0;
            ptr_odd_q   <= '0;
            ptr_even_q  <= '0;
            ptr_all_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            dropped_q   <= dropped_d;
            ptr_odd_q   <= ptr_odd_d;
            ptr_even_q  <= ptr_even_d;
            ptr_all_q   <= ptr_all_d;
        end
    end

    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_store = ram_store_q;

endmodule
